imem_fetch_arbiter: RTL and testbench

- Shares one combinational-read instruction memory port between the two cores of the two-core MESI system. Each core has its own request/grant/response channel.
- Arbitration is round-robin. Read data is registered, so every granted fetch has a fixed 1-cycle latency.
- The block also flags misaligned and out-of-range fetch addresses per core.
- It sits between the two core fetch stages and a single shared program memory.

---
 rtl/imem_fetch_arbiter_pkg.sv | 21 ++
 rtl/imem_fetch_arbiter_rr_arbiter2.sv | 27 ++
 rtl/imem_fetch_arbiter.sv | 84 ++++++++
 tb/tb_imem_fetch_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared definitions for the two-core instruction fetch arbiter.
// Covers the default widths, the fault NOP word and the per-core fetch channel types.
package imem_fetch_arbiter_pkg;

  localparam int ISIZE_DEF = 32;
  localparam int MEM_SIZE_DEF = 10;
  localparam logic [ISIZE_DEF-1:0] NOP_WORD_DEF = 32'h0000_0013;

  typedef struct packed {
    logic                 req;
    logic [ISIZE_DEF-1:0] addr;
  } fetch_req_t;

  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [ISIZE_DEF-1:0] rdata;
    logic                 fault;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_fetch_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with its priority pointer.
// Grants are forced low while reset is high, so a grant in a reset cycle never takes effect.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      gnt[0] = req[0] && (!req[1] || !rr_ptr);
      gnt[1] = req[1] && (!req[0] ||  rr_ptr);
    end
  end

  // Priority moves to the core that lost (or did not request) this cycle.
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (gnt[0]) rr_ptr <= 1'b1;
    else if (gnt[1]) rr_ptr <= 1'b0;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational-read instruction memory between two cores.
// Each granted fetch returns a registered response one cycle later, with fault decode.
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int               Isize    = ISIZE_DEF,
  parameter int               mem_size = MEM_SIZE_DEF,
  parameter logic [Isize-1:0] NOP_WORD = Isize'(NOP_WORD_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [Isize-1:0] addr0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [Isize-1:0] rdata0,
  output logic             fault0,
  input  logic             req1,
  input  logic [Isize-1:0] addr1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [Isize-1:0] rdata1,
  output logic             fault1,
  output logic [Isize-1:0] mem_addr,
  input  logic [Isize-1:0] mem_instr,
  output logic             busy
);

  function automatic logic fetch_fault(input logic [Isize-1:0] a);
    return (a[1:0] != 2'b00) || (a[Isize-1:mem_size] != '0);
  endfunction

  logic [1:0]       gnt_p0;
  logic             flt0_p0, flt1_p0;
  logic             vld0_p1, vld1_p1;
  logic [Isize-1:0] rdata0_p1, rdata1_p1;
  logic             fault0_p1, fault1_p1;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .gnt   (gnt_p0)
  );

  assign gnt0    = gnt_p0[0];
  assign gnt1    = gnt_p0[1];
  assign busy    = |gnt_p0;
  assign flt0_p0 = fetch_fault(addr0);
  assign flt1_p0 = fetch_fault(addr1);

  always_comb begin
    mem_addr = '0;
    if (gnt_p0[0])      mem_addr = addr0;
    else if (gnt_p0[1]) mem_addr = addr1;
  end

  // p0 -> p1: capture memory data (or the NOP on a fault) at the end of the grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
      fault0_p1 <= 1'b0;
      fault1_p1 <= 1'b0;
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
    end else begin
      vld0_p1   <= gnt_p0[0];
      vld1_p1   <= gnt_p0[1];
      fault0_p1 <= gnt_p0[0] && flt0_p0;
      fault1_p1 <= gnt_p0[1] && flt1_p0;
      if (gnt_p0[0]) rdata0_p1 <= flt0_p0 ? NOP_WORD : mem_instr;
      if (gnt_p0[1]) rdata1_p1 <= flt1_p0 ? NOP_WORD : mem_instr;
    end
  end

  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;
  assign rdata0  = rdata0_p1;
  assign rdata1  = rdata1_p1;
  assign fault0  = fault0_p1;
  assign fault1  = fault1_p1;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Randomized and directed bench for imem_fetch_arbiter against a behavioural reference model.
module tb_imem_fetch_arbiter;

  localparam int MEMSZ = 10;
  localparam int WORDS = 1 << (MEMSZ - 2);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, fault0, fault1, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_instr;

  logic [31:0] mem [WORDS];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          prio = 0;
  logic        e_rv0 = 1'b0, e_rv1 = 1'b0, e_f0 = 1'b0, e_f1 = 1'b0;
  logic [31:0] e_rd0 = '0, e_rd1 = '0;
  int          last_winner = -1;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.Isize(32), .mem_size(MEMSZ), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .fault0(fault0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .fault1(fault1),
    .mem_addr(mem_addr), .mem_instr(mem_instr), .busy(busy)
  );

  always_comb mem_instr = mem[mem_addr[MEMSZ-1:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd1 << MEMSZ));
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[(a / 4) % WORDS];
  endfunction

  // Evaluate one cycle (called mid-cycle, inputs stable).
  task automatic model_step();
    int winner;
    logic [31:0] wa;
    check("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv0});
    check("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv1});
    check("rdata0", rdata0, e_rd0);
    check("rdata1", rdata1, e_rd1);
    check("fault0", {31'd0, fault0}, {31'd0, e_f0});
    check("fault1", {31'd0, fault1}, {31'd0, e_f1});
    winner = -1;
    if (!reset) begin
      if (req0 && req1) winner = prio;
      else if (req0)    winner = 0;
      else if (req1)    winner = 1;
    end
    wa = (winner == 0) ? addr0 : (winner == 1) ? addr1 : 32'd0;
    check("gnt0", {31'd0, gnt0}, (winner == 0) ? 32'd1 : 32'd0);
    check("gnt1", {31'd0, gnt1}, (winner == 1) ? 32'd1 : 32'd0);
    check("busy", {31'd0, busy}, (winner >= 0) ? 32'd1 : 32'd0);
    check("mem_addr", mem_addr, wa);
    last_winner = winner;
    if (reset) begin
      prio = 0;
      e_rv0 = 0; e_rv1 = 0; e_f0 = 0; e_f1 = 0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      e_rv0 = (winner == 0);
      e_rv1 = (winner == 1);
      e_f0  = (winner == 0) && is_bad(addr0);
      e_f1  = (winner == 1) && is_bad(addr1);
      if (winner == 0) e_rd0 = is_bad(addr0) ? NOP : word_at(addr0);
      if (winner == 1) e_rd1 = is_bad(addr1) ? NOP : word_at(addr1);
      if (winner >= 0) prio = 1 - winner;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return (32'($urandom_range(0, WORDS - 1)) * 4) + 32'($urandom_range(1, 3));
    else if (r == 1) return $urandom | 32'h0000_0400;
    else             return 32'($urandom_range(0, WORDS - 1)) * 4;
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;

    // reset with both cores requesting
    reset = 1; req0 = 1; req1 = 1; addr0 = 32'h0; addr1 = 32'h4;
    step(); step();
    reset = 0;
    step();

    // single requester, consecutive words
    req1 = 0;
    for (int i = 0; i < 3; i++) begin
      req0 = 1; addr0 = 32'(i * 4);
      step();
    end
    req0 = 0;
    step();

    // contention
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) step();
    req0 = 0; req1 = 0;
    step();

    // misaligned, then aligned, on core 1
    req1 = 1; addr1 = 32'h6;
    step();
    addr1 = 32'h8;
    step();
    req1 = 0;
    step();

    // out of range on core 0 alongside core 1 traffic
    req0 = 1; addr0 = 32'h400; req1 = 1; addr1 = 32'hC;
    step(); step();
    addr0 = 32'h18;
    step();
    req0 = 0; req1 = 0;
    step();

    // reset in a cycle where core 1 would be granted, after priority moved to core 1
    req0 = 1; addr0 = 32'h1C;
    step();
    req0 = 0; req1 = 1; addr1 = 32'h24; reset = 1;
    step();
    reset = 0; req0 = 1; req1 = 1;
    step(); step();
    req0 = 0; req1 = 0;
    step();

    // randomized traffic obeying the hold-until-granted rule
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      step();
      if (!req0 || last_winner == 0) begin
        req0 = ($urandom_range(0, 3) != 0);
        addr0 = rand_addr();
      end
      if (!req1 || last_winner == 1) begin
        req1 = ($urandom_range(0, 3) != 0);
        addr1 = rand_addr();
      end
    end
    reset = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
